// File: rtl/alu_iface_pkg.sv
// Shared types for the UART-to-ALU command framer.
// FSM one-hot state codes and the counter width helper.
package alu_iface_pkg;

    localparam int N_STATES = 6;

    typedef enum logic [N_STATES-1:0] {
        ST_RX_A    = 6'b000001,
        ST_RX_B    = 6'b000010,
        ST_RX_OP   = 6'b000100,
        ST_EXEC    = 6'b001000,
        ST_TX_LOAD = 6'b010000,
        ST_TX_WAIT = 6'b100000
    } state_t;

    // Bits needed to hold counts 0 .. n_values-1 (at least one bit).
    function automatic int cnt_width(input int unsigned n_values);
        return (n_values < 2) ? 1 : $clog2(n_values);
    endfunction

endpackage

// File: rtl/alu_cmd_interface_rx_edge_detect.sv
// Registered rising-edge detector for the UART RX byte-done strobe.
// Yields one pulse per high level, however long the level lasts.
module rx_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_level,
    output logic o_pulse
);

    logic level_q;

    // Remember the previous level and flag a low-to-high transition.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            level_q <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            level_q <= i_level;
            o_pulse <= i_level & ~level_q;
        end
    end

endmodule

// File: rtl/alu_cmd_interface.sv
// UART-to-ALU command framer: A, B, opcode in; ALU result out to TX.
// Optional inter-byte timeout enabled by defining ALU_IFACE_TIMEOUT_EN.
module alu_cmd_interface
    import alu_iface_pkg::*;
#(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int ALU_LATENCY    = 0,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic [NB_DATA-1:0] i_alu_result,
    input  logic               i_tx_done,
    output logic [NB_DATA-1:0] o_dato_A,
    output logic [NB_DATA-1:0] o_dato_B,
    output logic [NB_OP-1:0]   o_OP,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_start,
    output logic               o_busy,
    output logic               o_rx_overrun,
    output logic               o_timeout
);

    localparam int WW = cnt_width(ALU_LATENCY + 1);

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic          byte_ev;
    logic          tmo_hit;

    rx_edge_detect u_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_level (i_rx_done),
        .o_pulse (byte_ev)
    );

`ifdef ALU_IFACE_TIMEOUT_EN
    localparam int TW = cnt_width(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;
    logic          in_gap;

    assign in_gap  = (state == ST_RX_B) || (state == ST_RX_OP);
    // A byte arriving on the last count wins over the abort.
    assign tmo_hit = in_gap && !byte_ev &&
                     (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Inter-byte gap counter, cleared by accepted bytes or outside the gap.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tmo_cnt   <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= tmo_hit;
            if (!in_gap || byte_ev || tmo_hit)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit   = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // Frame FSM with registered ALU operands, TX byte and status pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state        <= ST_RX_A;
            wait_cnt     <= '0;
            o_dato_A     <= '0;
            o_dato_B     <= '0;
            o_OP         <= '0;
            o_tx_data    <= '0;
            o_tx_start   <= 1'b0;
            o_busy       <= 1'b0;
            o_rx_overrun <= 1'b0;
        end else begin
            o_tx_start   <= 1'b0;
            o_rx_overrun <= byte_ev && o_busy;
            case (state)
                ST_RX_A: begin
                    if (byte_ev) begin
                        o_dato_A <= i_rx_data;
                        state    <= ST_RX_B;
                    end
                end
                ST_RX_B: begin
                    if (byte_ev) begin
                        o_dato_B <= i_rx_data;
                        state    <= ST_RX_OP;
                    end else if (tmo_hit) begin
                        state <= ST_RX_A;
                    end
                end
                ST_RX_OP: begin
                    if (byte_ev) begin
                        o_OP     <= i_rx_data[NB_OP-1:0];
                        wait_cnt <= '0;
                        o_busy   <= 1'b1;
                        state    <= ST_EXEC;
                    end else if (tmo_hit) begin
                        state <= ST_RX_A;
                    end
                end
                ST_EXEC: begin
                    if (wait_cnt == WW'(ALU_LATENCY)) begin
                        o_tx_data <= i_alu_result;
                        state     <= ST_TX_LOAD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_TX_LOAD: begin
                    o_tx_start <= 1'b1;
                    state      <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (i_tx_done) begin
                        o_busy <= 1'b0;
                        state  <= ST_RX_A;
                    end
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_RX_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_interface.sv
// Self-checking bench for alu_cmd_interface (latency 0 and latency 3).
// Build with ALU_IFACE_TIMEOUT_EN defined to exercise the timeout path.
module tb_alu_cmd_interface;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_done3 = 1'b1;

    logic [7:0] alu_res, alu_res3;
    logic [7:0] dato_a, dato_b, tx_data;
    logic [5:0] op;
    logic       tx_start, busy, ovr, tmo;
    logic [7:0] dato_a3, dato_b3, tx_data3;
    logic [5:0] op3;
    logic       tx_start3, busy3, ovr3, tmo3;

    int n_tests = 0;
    int n_fail  = 0;
    int start_cnt = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_f(input logic [7:0] a, b,
                                         input logic [5:0] o);
        case (o)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_res  = alu_f(dato_a, dato_b, op);
    assign alu_res3 = alu_f(dato_a3, dato_b3, op3);

    alu_cmd_interface #(
        .NB_DATA(8), .NB_OP(6), .ALU_LATENCY(0), .TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_res), .i_tx_done(tx_done),
        .o_dato_A(dato_a), .o_dato_B(dato_b), .o_OP(op),
        .o_tx_data(tx_data), .o_tx_start(tx_start), .o_busy(busy),
        .o_rx_overrun(ovr), .o_timeout(tmo)
    );

    alu_cmd_interface #(
        .NB_DATA(8), .NB_OP(6), .ALU_LATENCY(3), .TIMEOUT_CYCLES(50)
    ) dut3 (
        .i_clock(clk), .i_reset(rst),
        .i_rx_data(rx_data), .i_rx_done(rx_done),
        .i_alu_result(alu_res3), .i_tx_done(tx_done3),
        .o_dato_A(dato_a3), .o_dato_B(dato_b3), .o_OP(op3),
        .o_tx_data(tx_data3), .o_tx_start(tx_start3), .o_busy(busy3),
        .o_rx_overrun(ovr3), .o_timeout(tmo3)
    );

    always @(negedge clk) begin
        if (tx_start) start_cnt++;
        if (ovr) ovr_cnt++;
        if (tmo) tmo_cnt++;
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] exp_op;
        logic [7:0] exp_res;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (hold) @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_start(output int n, output logic [7:0] d);
        n = -1;
        d = 8'h00;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (tx_start) begin
                n = i;
                d = tx_data;
                break;
            end
        end
    endtask

    task automatic finish_tx(input string nm, input logic [7:0] exp);
        repeat (10) @(negedge clk);
        check({nm, " data_hold"}, tx_data, exp);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        check({nm, " idle"}, busy, 0);
    endtask

    task automatic run_frame(input string nm, input logic [7:0] a, b, ob,
                             input logic [5:0] eop, input logic [7:0] eres);
        int n;
        int s0;
        logic [7:0] d;
        s0 = start_cnt;
        send_byte(a, 1);
        send_byte(b, 1);
        send_byte(ob, 1);
        wait_start(n, d);
        check({nm, " start_seen"}, n > 0, 1);
        check({nm, " tx_data"}, d, eres);
        check({nm, " A"}, dato_a, a);
        check({nm, " B"}, dato_b, b);
        check({nm, " OP"}, op, eop);
        check({nm, " busy"}, busy, 1);
        @(negedge clk);
        check({nm, " start_once"}, start_cnt - s0, 1);
        finish_tx(nm, eres);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        int s0;
        int o0;
        logic [7:0] d;

        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08};
        vecs[1] = '{8'h10, 8'h07, 8'h22, 6'h22, 8'h09};
        vecs[2] = '{8'hF0, 8'h3C, 8'h24, 6'h24, 8'h30};
        vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
        vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
        vecs[5] = '{8'hFF, 8'h01, 8'hE0, 6'h20, 8'h00};
        vecs[6] = '{8'h12, 8'h34, 8'h3F, 6'h3F, 8'h00};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst A", dato_a, 0);
        check("rst B", dato_b, 0);
        check("rst OP", op, 0);
        check("rst tx_data", tx_data, 0);
        check("rst start", tx_start, 0);
        check("rst busy", busy, 0);
        check("rst ovr", ovr, 0);
        check("rst tmo", tmo, 0);

        // Long RX level captures a single byte.
        send_byte(8'h7F, 4);
        repeat (2) @(negedge clk);
        check("hold A", dato_a, 8'h7F);
        check("hold B", dato_b, 8'h00);
        check("hold busy", busy, 0);
        send_byte(8'h01, 1);
        send_byte(8'h20, 1);
        wait_start(n, d);
        check("hold B2", dato_b, 8'h01);
        check("hold res", d, 8'h80);
        finish_tx("hold", 8'h80);

        for (int i = 0; i < 7; i++)
            run_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                      vecs[i].opb, vecs[i].exp_op, vecs[i].exp_res);

        // Byte during TX_WAIT is dropped.
        send_byte(8'h09, 1);
        send_byte(8'h04, 1);
        send_byte(8'h22, 1);
        wait_start(n, d);
        check("ovr res", d, 8'h05);
        o0 = ovr_cnt;
        send_byte(8'hAA, 1);
        repeat (3) @(negedge clk);
        check("ovr pulse", ovr_cnt - o0, 1);
        check("ovr A", dato_a, 8'h09);
        check("ovr busy", busy, 1);
        finish_tx("ovr", 8'h05);
        run_frame("post_ovr", 8'h21, 8'h12, 8'h26, 6'h26, 8'h33);

        // tx_done seen only in TX_LOAD must not end the transfer.
        send_byte(8'h02, 1);
        send_byte(8'h02, 1);
        @(negedge clk);
        rx_data = 8'h20;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check("txload start", tx_start, 1);
        repeat (3) @(negedge clk);
        check("txload busy", busy, 1);
        finish_tx("txload", 8'h04);

        // Reset in RX_OP discards the partial frame.
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        s0 = start_cnt;
        do_reset();
        check("mid_rst A", dato_a, 0);
        check("mid_rst B", dato_b, 0);
        check("mid_rst busy", busy, 0);
        run_frame("after_rst", 8'h01, 8'h02, 8'h20, 6'h20, 8'h03);
        check("after_rst starts", start_cnt - s0, 1);

        // Latency 3: o_tx_start 6 cycles after the opcode edge.
        do_reset();
        send_byte(8'h02, 1);
        send_byte(8'h03, 1);
        @(negedge clk);
        rx_data = 8'h20;
        rx_done = 1'b1;
        n = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) rx_done = 1'b0;
            if (tx_start3) begin
                n = i;
                break;
            end
        end
        check("lat3 cycles", n - 1, 6);
        check("lat3 data", tx_data3, 8'h05);
        finish_tx("lat3_dut0", 8'h05);

`ifdef ALU_IFACE_TIMEOUT_EN
        // Gap expiry aborts the frame.
        do_reset();
        o0 = tmo_cnt;
        @(negedge clk);
        rx_data = 8'h44;
        rx_done = 1'b1;
        n = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (i == 1) rx_done = 1'b0;
            if (tmo) begin
                n = i;
                break;
            end
        end
        check("tmo cycle", n, 52);
        @(negedge clk);
        check("tmo once", tmo_cnt - o0, 1);
        check("tmo A kept", dato_a, 8'h44);
        run_frame("post_tmo", 8'h04, 8'h05, 8'h20, 6'h20, 8'h09);

        // Byte on the last gap cycle wins.
        o0 = tmo_cnt;
        @(negedge clk);
        rx_data = 8'h30;
        rx_done = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1 || i == 51) rx_done = 1'b0;
            if (i == 50) begin
                rx_data = 8'h06;
                rx_done = 1'b1;
            end
        end
        check("late B", dato_b, 8'h06);
        check("late no_tmo", tmo_cnt - o0, 0);
        send_byte(8'h20, 1);
        wait_start(n, d);
        check("late res", d, 8'h36);
        finish_tx("late", 8'h36);
`else
        check("no tmo pulses", tmo_cnt, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
